// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - observer that checks a counter holds or increments by one each cycle
// Optional first-error capture enabled by defining COUNT_MONITOR_FIRST_ERR_EN.
module count_monitor #(
    parameter int WIDTH       = 8,
    parameter int LOCK_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap,
    output logic [ERR_W-1:0] wrap_count,
    output logic             first_valid,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev_count;
    logic             prev_en;
    logic [7:0]       good_cnt;
    logic [WIDTH-1:0] exp_count;
    logic             match;
    logic             mismatch;
    logic             wrap_hit;

    always_comb begin
        exp_count = prev_en ? prev_count + WIDTH'(1) : prev_count;
        match     = (count == exp_count);
        mismatch  = (state == TRACK) && !match && !clear;
        // A correct increment out of all-ones necessarily lands on zero.
        wrap_hit  = (state == TRACK) && match && prev_en && (&prev_count);
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = TRACK;
                TRACK:   state_nxt = match ? TRACK : RESYNC;
                RESYNC:  state_nxt = TRACK;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_count <= '0;
            prev_en    <= 1'b0;
            good_cnt   <= 8'd0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            wrap       <= 1'b0;
            wrap_count <= '0;
        end else begin
            prev_count <= count;
            prev_en    <= enable;
            err        <= 1'b0;
            wrap       <= 1'b0;
            if (clear) begin
                good_cnt   <= 8'd0;
                locked     <= 1'b0;
                err_count  <= '0;
                wrap_count <= '0;
            end else if (state == IDLE) begin
                good_cnt <= 8'd0;
                locked   <= 1'b0;
            end else if (state == TRACK) begin
                if (match) begin
                    if (good_cnt < 8'(LOCK_CYCLES)) begin
                        good_cnt <= good_cnt + 8'd1;
                    end
                    if (good_cnt >= 8'(LOCK_CYCLES - 1)) begin
                        locked <= 1'b1;
                    end
                    if (wrap_hit) begin
                        wrap <= 1'b1;
                        if (wrap_count != '1) begin
                            wrap_count <= wrap_count + ERR_W'(1);
                        end
                    end
                end else begin
                    err      <= 1'b1;
                    locked   <= 1'b0;
                    good_cnt <= 8'd0;
                    if (err_count != '1) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                end
            end
        end
    end

`ifdef COUNT_MONITOR_FIRST_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_valid <= 1'b0;
            first_exp   <= '0;
            first_obs   <= '0;
        end else if (clear) begin
            first_valid <= 1'b0;
            first_exp   <= '0;
            first_obs   <= '0;
        end else if (mismatch && !first_valid) begin
            first_valid <= 1'b1;
            first_exp   <= exp_count;
            first_obs   <= count;
        end
    end
`else
    assign first_valid = 1'b0;
    assign first_exp   = '0;
    assign first_obs   = '0;
`endif

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Synthesizable observer on the consumer side of the counter output interface (clk, rst_n, enable, count).
- Watches the same enable wire and the count bus and checks every cycle that count held or incremented by exactly 1 modulo 2^WIDTH.
- Reports a lock status, error pulses, a saturating error tally and a wrap tally.
- Sits beside the counter in benches and designs as a self-check block; it has no effect on the counter.

Parameters:
- WIDTH, 8, width of the observed count bus.
- LOCK_CYCLES, 4, consecutive correct comparisons needed before locked asserts (1..255).
- ERR_W, 8, width of err_count and wrap_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  same net that drives the counter's enable.
- count  input  WIDTH  observed counter output.
- clear  input  1  synchronous restart of monitor state and tallies.
- locked  output  1  high while tracking and LOCK_CYCLES good compares have been seen.
- err  output  1  one-cycle pulse on a mismatch.
- err_count  output  ERR_W  saturating mismatch tally.
- wrap  output  1  one-cycle pulse when a correct max->0 increment is seen.
- wrap_count  output  ERR_W  saturating tally of correct wraps.
- first_valid  output  1  first-error capture valid (optional feature).
- first_exp  output  WIDTH  expected value at first error (optional feature).
- first_obs  output  WIDTH  observed value at first error (optional feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - State=IDLE; prev_count=0, prev_en=0, good_cnt=0.
- Every rising edge, prev_count<=count and prev_en<=enable, except in IDLE where only the capture happens.
- Expected value: exp = prev_en ? prev_count+1 (wraps, WIDTH bits) : prev_count.
- States:
  - IDLE: capture count/enable into prev; good_cnt=0; go to TRACK next edge. locked=0.
  - TRACK, count==exp: good_cnt++ (saturates at LOCK_CYCLES). locked asserts on the edge where good_cnt reaches LOCK_CYCLES, so it is visible the following cycle.
  - TRACK, count!=exp: err=1 for one cycle; err_count++ (holds at all-ones); locked<=0; good_cnt<=0; go to RESYNC.
  - RESYNC: one cycle. prev is reloaded from the current count/enable (no compare), then go to TRACK.
- Wrap detection: in TRACK, if prev_en=1, prev_count=all-ones and count==0, then wrap=1 and wrap_count++ (saturating).
- A wrong wrap is an error only; it is not counted as a wrap.
- Latency: err/wrap assert one cycle after the offending count value is present on the bus.
- clear=1:
  - Has priority over compare.
  - Next state=IDLE; err_count, wrap_count, locked, err, wrap and the first_* outputs go to 0.
- Simultaneous clear and mismatch: clear wins; no err pulse.
- enable toggling every cycle is legal: each compare uses the enable registered one edge earlier.
- Reset mid-operation returns to IDLE immediately. The monitor does not expect count=0 after reset; it resynchronizes in IDLE.

Optional Feature:
- COUNT_MONITOR_FIRST_ERR_EN defined:
  - On the first err after reset/clear, first_exp<=exp, first_obs<=count, first_valid<=1.
  - These outputs then hold until reset or clear; later errors do not overwrite them.
- Not defined: first_valid, first_exp and first_obs are tied to 0 and no capture registers are built.

Test Plan:
- Reset 10 cycles, enable=0 for 5 cycles, then enable=1 for 100 cycles with count driven by a correct WIDTH=8 counter -> locked=1 by the 6th cycle after reset release; err_count=0; wrap_count=0.
- Correct counter run 300 enabled cycles -> exactly one wrap pulse at 255->0; wrap_count=1; err never asserts.
- Force count from 0x10 to 0x13 while enable=1 -> err pulses once; err_count=1; locked drops, then reasserts LOCK_CYCLES+1 cycles later. With the macro: first_exp=0x11, first_obs=0x13, first_valid=1.
- count changes 0x20->0x21 while prev_en=0 -> err=1. A second injected error -> err_count=2; first_* still holds the first error's values.
- Assert clear in the same cycle as an injected mismatch -> no err pulse; err_count=0; locked=0; state returns to IDLE, then relocks.
- Drop rst_n mid-run with err_count=3 -> all outputs 0 asynchronously. After release the monitor relocks with no spurious err.
